// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state codes, frame width and frame/parity helpers.
// Used by both the device-side transmitter and the ps2_keyboard receiver.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;

    typedef logic [1:0] ps2_state_t;

    localparam ps2_state_t ST_IDLE = 2'd0;
    localparam ps2_state_t ST_HIGH = 2'd1;
    localparam ps2_state_t ST_LOW  = 2'd2;
    localparam ps2_state_t ST_GAP  = 2'd3;

    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    // Bit 0 is the start bit, so the vector shifts out LSB first.
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
        return {1'b1, ps2_odd_parity(b), b, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_tick_div.sv
// Loadable down-counter; tc is high while the count sits at zero.
// A load restarts the count, so each timed state lasts load_val+1 cycles.
module ps2_tick_div #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_r;

    // Count down to zero and hold there until the next load.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {W{1'b0}}) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign tc    = (count_r == {W{1'b0}});

endmodule

// File: rtl/ps2_device_tx.sv
// Keyboard-side PS/2 transmitter: serialises bytes into 11-bit device-to-host frames.
// Optional host-inhibit handling on ps2_clk_in is enabled with PS2_TX_INHIBIT_EN.
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 2500,
    parameter int GAP_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    input  logic       ps2_clk_in,
    output logic       busy,
    output logic       done
);

    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    ps2_state_t                state_r;
    ps2_state_t                next_state_s;
    logic [3:0]                bit_idx_r;
    logic [PS2_FRAME_BITS-1:0] frame_r;
    logic [PS2_FRAME_BITS-1:0] frame_s;
    logic                      ps2_clk_r;
    logic                      ps2_data_r;
    logic                      in_ready_r;
    logic                      done_r;
    logic                      abort_r;
    logic                      abort_s;
    logic                      accept_s;
    logic                      inhibit_s;
    logic                      load_s;
    logic [CW-1:0]             load_val_s;
    logic [CW-1:0]             count_s;
    logic                      tc_s;

`ifdef PS2_TX_INHIBIT_EN
    logic [1:0] clk_in_sync_r;

    // Two-flop synchroniser for the host clock line; idles high.
    always_ff @(posedge clk) begin
        if (clr) begin
            clk_in_sync_r <= 2'b11;
        end else begin
            clk_in_sync_r <= {clk_in_sync_r[0], ps2_clk_in};
        end
    end

    assign inhibit_s = ~clk_in_sync_r[1];
`else
    logic unused_clk_in_s;
    assign unused_clk_in_s = ps2_clk_in;
    assign inhibit_s       = 1'b0;
`endif

    assign frame_s  = ps2_frame(in_data);
    assign accept_s = (state_r == ST_IDLE) && in_ready_r && in_valid;

    ps2_tick_div #(.W(CW)) u_tick_div (
        .clk      (clk),
        .clr      (clr),
        .load     (load_s),
        .load_val (load_val_s),
        .count    (count_s),
        .tc       (tc_s)
    );

    // Next-state decode; every transition reloads the shared timer.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        load_val_s   = HALF_LOAD;
        abort_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_HIGH;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (inhibit_s && (bit_idx_r < 4'd10)) begin
                    next_state_s = ST_GAP;
                    load_s       = 1'b1;
                    load_val_s   = GAP_LOAD;
                    abort_s      = 1'b1;
                end else if (tc_s) begin
                    next_state_s = ST_LOW;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (tc_s && (bit_idx_r < 4'd10)) begin
                    next_state_s = ST_HIGH;
                    load_s       = 1'b1;
                end else if (tc_s) begin
                    next_state_s = ST_GAP;
                    load_s       = 1'b1;
                    load_val_s   = GAP_LOAD;
                end else begin
                    next_state_s = ST_LOW;
                end
            end
            ST_GAP: begin
                if (tc_s) begin
                    next_state_s = ST_IDLE;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                load_s       = 1'b1;
            end
        endcase
    end

    // State, frame latch and registered line/handshake outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r    <= ST_IDLE;
            bit_idx_r  <= 4'd0;
            frame_r    <= {PS2_FRAME_BITS{1'b0}};
            ps2_clk_r  <= 1'b1;
            ps2_data_r <= 1'b1;
            in_ready_r <= 1'b0;
            done_r     <= 1'b0;
            abort_r    <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            in_ready_r <= (next_state_s == ST_IDLE) && !inhibit_s;
            // The GAP state runs GAP_CYCLES+1 cycles; done marks its final one.
            done_r     <= (state_r == ST_GAP) && (count_s == CNT_ONE) && !abort_r;
            if (accept_s) begin
                frame_r    <= frame_s;
                bit_idx_r  <= 4'd0;
                ps2_clk_r  <= 1'b1;
                ps2_data_r <= frame_s[0];
                abort_r    <= 1'b0;
            end else if ((state_r == ST_HIGH) && (next_state_s == ST_LOW)) begin
                ps2_clk_r  <= 1'b0;
            end else if ((state_r == ST_LOW) && (next_state_s == ST_HIGH)) begin
                ps2_clk_r  <= 1'b1;
                bit_idx_r  <= bit_idx_r + 4'd1;
                ps2_data_r <= frame_r[bit_idx_r + 4'd1];
            end else if ((state_r != ST_GAP) && (next_state_s == ST_GAP)) begin
                ps2_clk_r  <= 1'b1;
                ps2_data_r <= 1'b1;
                abort_r    <= abort_s;
            end else begin
                ps2_clk_r  <= ps2_clk_r;
                ps2_data_r <= ps2_data_r;
            end
        end
    end

    assign ps2_clk  = ps2_clk_r;
    assign ps2_data = ps2_data_r;
    assign in_ready = in_ready_r;
    assign busy     = (state_r != ST_IDLE);
    assign done     = done_r;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Self-checking bench for ps2_device_tx: frame-offset reference model, line decoder,
// directed timing pins and a randomized phase.
module tb_ps2_device_tx;

    localparam int D         = 4;
    localparam int G         = 8;
    localparam int FRAME_END = 22 * D;
    localparam int DONE_OFF  = 22 * D + G + 1;

    logic       clk;
    logic       clr;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ps2_clk_in;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    ps2_device_tx #(.CLK_DIV(D), .GAP_CYCLES(G)) dut (
        .clk        (clk),
        .clr        (clr),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2_clk_in (ps2_clk_in),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out (cycle %0d)", name, cyc);
    endtask

    // Reference model: a frame is described purely by its offset from the accept cycle.
    logic        m_live = 1'b0;
    logic        m_active = 1'b0;
    int          m_off = 0;
    logic [10:0] m_frame;
    logic        m_par;
    logic        e_clk = 1'b1, e_data = 1'b1, e_ready = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    logic [7:0]  exp_bytes[$];
    int          dec_n = 0;
    logic [10:0] dec_sh;
    logic        dec_prev = 1'b1;

    always @(posedge clk) begin
        if (clr) begin
            m_active = 1'b0;
            e_clk = 1'b1; e_data = 1'b1; e_ready = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            exp_bytes.delete();
            dec_n  = 0;
            m_live = 1'b1;
        end else if (m_live) begin
            if (!m_active && e_ready && in_valid) begin
                m_active = 1'b1;
                m_off    = 0;
                m_par    = ($countones(in_data) % 2 == 0);
                m_frame  = {1'b1, m_par, in_data, 1'b0};
                exp_bytes.push_back(in_data);
            end
            if (m_active) begin
                m_off++;
                if (m_off > DONE_OFF) m_active = 1'b0;
            end
            if (m_active) begin
                e_busy  = 1'b1;
                e_ready = 1'b0;
                e_done  = (m_off == DONE_OFF);
                if (m_off <= FRAME_END) begin
                    e_clk  = (((m_off - 1) % (2 * D)) < D);
                    e_data = m_frame[(m_off - 1) / (2 * D)];
                end else begin
                    e_clk  = 1'b1;
                    e_data = 1'b1;
                end
            end else begin
                e_busy = 1'b0; e_ready = 1'b1; e_done = 1'b0; e_clk = 1'b1; e_data = 1'b1;
            end
        end
    end

    // Per-cycle compare against the model, plus a receiver-style decode on falling edges.
    always @(negedge clk) begin
        if (m_live) begin
            chk("ps2_clk",  ps2_clk,  e_clk);
            chk("ps2_data", ps2_data, e_data);
            chk("in_ready", in_ready, e_ready);
            chk("busy",     busy,     e_busy);
            chk("done",     done,     e_done);
            if (dec_prev && !ps2_clk) begin
                dec_sh[dec_n] = ps2_data;
                dec_n++;
                if (dec_n == 11) begin
                    chk("rx_start",  dec_sh[0], 1'b0);
                    chk("rx_stop",   dec_sh[10], 1'b1);
                    chk("rx_parity", ^dec_sh[9:1], 1'b1);
                    if (exp_bytes.size() == 0) timeout_fail("rx_unexpected_frame");
                    else chk("rx_byte", dec_sh[8:1], exp_bytes.pop_front());
                    dec_n = 0;
                end
            end
            dec_prev = ps2_clk;
        end
    end

    task automatic send(input logic [7:0] b, output int t);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) timeout_fail("send_wait_ready");
        in_data  = b;
        in_valid = 1'b1;
        t        = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic observe(input int t0, input int ncyc, output logic [10:0] bits,
                           output int first_fall, output int done_off);
        logic prev;
        int   n;
        prev = 1'b1; n = 0; bits = 11'd0; first_fall = -1; done_off = -1;
        repeat (ncyc) begin
            @(negedge clk);
            if (prev && !ps2_clk) begin
                if (first_fall < 0) first_fall = cyc - t0;
                if (n < 11) bits[n] = ps2_data;
                n++;
            end
            if (done && done_off < 0) done_off = cyc - t0;
            prev = ps2_clk;
        end
    endtask

    initial begin
        int          t, t1, t2, ff, doff, acc, n;
        logic [10:0] bits;

        clr = 1'b1; in_valid = 1'b0; in_data = 8'h00; ps2_clk_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ps2_clk",  ps2_clk,  1'b1);
        chk("rst_ps2_data", ps2_data, 1'b1);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy",     busy,     1'b0);
        chk("rst_done",     done,     1'b0);
        clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1'b1);

        // 0x1C: bit pattern and key timing offsets
        send(8'h1C, t);
        observe(t, 110, bits, ff, doff);
        chk("f1C_bits", bits, 11'h438);
        chk("f1C_first_fall", ff, 5);
        chk("f1C_done", doff, 97);

        // 0xF0: parity bit set
        send(8'hF0, t);
        observe(t, 110, bits, ff, doff);
        chk("fF0_bits", bits, 11'h7E0);

        // in_valid held: back-to-back frames
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) timeout_fail("b2b_wait_ready");
        in_data = 8'hF0; in_valid = 1'b1;
        acc = 0; t1 = -1; t2 = -1;
        for (int i = 0; i < 250; i++) begin
            if (in_ready && in_valid) begin
                acc++;
                if (acc == 1) t1 = cyc;
                else t2 = cyc;
            end
            @(posedge clk);
            #1;
            if (acc == 1) in_data = 8'h1C;
            if (acc >= 2) in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2b_accepts", acc, 2);
        chk("b2b_spacing", t2 - t1, 98);

        // clr during bit 4 abandons the frame
        send(8'h33, t);
        repeat (34) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("mid_clr_ps2_clk",  ps2_clk,  1'b1);
        chk("mid_clr_ps2_data", ps2_data, 1'b1);
        chk("mid_clr_busy",     busy,     1'b0);
        clr = 1'b0;
        @(negedge clk);
        chk("mid_clr_ready", in_ready, 1'b1);
        send(8'h55, t);
        observe(t, 110, bits, ff, doff);
        chk("f55_bits", bits, 11'h6AA);

        // in_valid toggling mid-frame is ignored
        send(8'h1C, t);
        fork
            observe(t, 110, bits, ff, doff);
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1 in_valid = ~in_valid;
                    in_data = 8'hAA;
                end
                in_valid = 1'b0;
            end
        join
        chk("toggle_bits", bits, 11'h438);
        chk("toggle_done", doff, 97);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom_range(0, 255));
            clr      = ($urandom_range(0, 299) == 0);
`ifndef PS2_TX_INHIBIT_EN
            ps2_clk_in = 1'($urandom_range(0, 1));
`endif
        end
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        repeat (120) @(negedge clk);
        chk("drain_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
